cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Run-control scheduler for the multicycle CPU clock.
- Derives one-cycle CPU clock-enable pulses from the board clock at a switch-selected fast or slow rate.
- Sequences them under four modes: halt, free run, single-step (debounced button) and N-cycle burst.
- Halts automatically on a CPU breakpoint; exposes state and an enable-pulse count for the display logic.

Parameters:
DIV_FAST, 4, log2 of board clocks per tick in fast mode
DIV_SLOW, 26, log2 of board clocks per tick in slow mode (must be > DIV_FAST, ≤ 32)
DB_BITS, 20, debounce counter width; a button level is accepted after 2^DB_BITS-1 stable cycles

Ports:
clk  in  1  board clock
rst  in  1  asynchronous, active-high reset
run_sw  in  1  raw switch; 1 = request free run
slow_sw  in  1  raw switch; 1 = slow rate, 0 = fast rate
step_btn  in  1  raw push-button, single step
burst_btn  in  1  raw push-button, start burst
burst_len  in  8  number of CPU cycles per burst (sampled on burst start)
bkpt_hit  in  1  from CPU, synchronous to clk; breakpoint reached
cpu_ce  out  1  CPU clock enable, one clk cycle wide per CPU cycle
state  out  2  00 HALT, 01 RUN, 10 STEP, 11 BURST
bkpt_halted  out  1  sticky: halted by breakpoint
ce_count  out  32  number of cpu_ce pulses issued, wraps modulo 2^32

Behaviour:
- Reset (asynchronous):
  - state = HALT; cpu_ce, bkpt_halted, ce_count = 0.
  - 32-bit prescaler, burst counter and debounce counters = 0.
  - Accepted button levels = 0.
- Input conditioning:
  - run_sw, slow_sw, step_btn, burst_btn each pass through a 2-flop synchroniser.
  - Buttons are then debounced: the counter clears whenever the synchronised level equals the accepted level; otherwise it increments. At all-ones, the accepted level takes the new value and the counter clears.
  - A 0→1 change of an accepted level produces a one-clk press pulse.
- Prescaler:
  - Free-running, increments every clk.
  - tick = 1 when prescaler[D-1:0] is all ones, with D = DIV_SLOW if synced slow_sw else DIV_FAST.
  - A rate change takes effect at the next qualifying tick. The prescaler is never cleared except by rst.
- cpu_ce is registered: asserted the clk after a tick that the current state grants, high for exactly one clk. Never asserted in HALT.
- FSM (transitions take effect on the clk edge):
  - HALT, priority order:
    - run_sw=1 and bkpt_halted=0 → RUN.
    - Else step press → STEP.
    - Else burst press with burst_len≠0 → BURST; remaining ← burst_len.
    - burst press with burst_len=0 is ignored.
  - RUN:
    - Grants every tick.
    - run_sw=0 → HALT; no cpu_ce after the transition edge.
  - STEP: grants the first tick, then → HALT on the same edge that raises cpu_ce. Exactly one pulse per press.
  - BURST:
    - Grants every tick; remaining decrements on each grant.
    - Grant with remaining=1 → HALT; exactly burst_len pulses in total.
    - run_sw changes are ignored until the burst ends.
- Breakpoint:
  - bkpt_hit=1 in RUN, STEP or BURST → HALT and bkpt_halted ← 1, with priority over a same-cycle tick (no pulse issued).
  - bkpt_halted clears only when synced run_sw=0. While it is set, HALT→RUN is blocked; step and burst remain allowed.
  - bkpt_hit in HALT has no effect.
- Button presses outside HALT are dropped, not queued.
- ce_count increments on every cpu_ce cycle; wraps FFFF_FFFF→0.
- rst mid-burst or mid-run: immediate HALT; all counters cleared; no pulse on the deassert cycle.

Test Plan:
All scenarios use DIV_FAST=2, DIV_SLOW=4, DB_BITS=3.
- Reset, run_sw=1, slow_sw=0 → state=01 after sync latency; cpu_ce pulses every 4 clk; after 40 clk ce_count≈10. Set slow_sw=1 → pulse spacing 16 clk from next tick.
- run_sw=0, step_btn held 12 clk with 2-clk glitches before it → exactly one cpu_ce, state 10→00, ce_count=1. A glitch shorter than 7 clk → no pulse.
- burst_len=5, burst press → exactly 5 pulses 4 clk apart, state returns to 00, ce_count=5. burst_len=0 press → no pulse, state stays 00.
- RUN with bkpt_hit pulsed coincident with a tick → no pulse that cycle, state=00, bkpt_halted=1. run_sw stays 1 → remains HALT. run_sw 0 then 1 → bkpt_halted=0, RUN resumes.
- Assert rst during burst of 200 after 3 pulses → cpu_ce=0, state=00, ce_count=0 immediately. Force ce_count to FFFF_FFFF, one pulse → ce_count=0.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run-control scheduler for the multicycle CPU clock.
// Turns the board clock into one-clk CPU enable pulses at a switch-selected
// rate and sequences them as halt / free run / single step / N-cycle burst,
// dropping to halt on a CPU breakpoint.

// Button debouncer: accepts a new level after it has differed from the
// accepted level for 2^DB_BITS consecutive clocks; emits a one-clk pulse
// when the accepted level rises.
module cpu_run_ctrl_db #(
  parameter int DB_BITS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic press
);
  logic [DB_BITS-1:0] cnt;
  logic               acc;
  logic               cnt_full;

  assign cnt_full = &cnt;

  // Count while the synchronised level disagrees with the accepted one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      acc   <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (din == acc) begin
        cnt <= '0;
      end else if (cnt_full) begin
        acc   <= din;
        cnt   <= '0;
        press <= din;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module cpu_run_ctrl #(
  parameter int DIV_FAST = 4,
  parameter int DIV_SLOW = 26,
  parameter int DB_BITS  = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_sw,
  input  logic        slow_sw,
  input  logic        step_btn,
  input  logic        burst_btn,
  input  logic [7:0]  burst_len,
  input  logic        bkpt_hit,
  output logic        cpu_ce,
  output logic [1:0]  state,
  output logic        bkpt_halted,
  output logic [31:0] ce_count
);
  localparam logic [1:0] S_HALT  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_STEP  = 2'b10;
  localparam logic [1:0] S_BURST = 2'b11;

  // Low-bit masks for the tick compare; built 64 wide so DIV_SLOW=32 works.
  localparam logic [63:0] MASK_F64 = (64'd1 << DIV_FAST) - 64'd1;
  localparam logic [63:0] MASK_S64 = (64'd1 << DIV_SLOW) - 64'd1;
  localparam logic [31:0] MASK_F   = MASK_F64[31:0];
  localparam logic [31:0] MASK_S   = MASK_S64[31:0];

  // {burst_btn, step_btn, slow_sw, run_sw}
  logic [3:0]  sync1, sync2;
  logic        run_s, slow_s;
  logic [1:0]  press;       // {burst, step}
  logic [31:0] presc;
  logic [31:0] mask;
  logic        tick;
  logic [7:0]  rem, rem_n;
  logic [1:0]  state_n;
  logic        grant;
  logic        hit_halt;

  // Two-flop synchronisers for all raw switch and button inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {burst_btn, step_btn, slow_sw, run_sw};
      sync2 <= sync1;
    end
  end

  assign run_s  = sync2[0];
  assign slow_s = sync2[1];

  cpu_run_ctrl_db #(.DB_BITS(DB_BITS)) u_db [1:0] (
    .clk   (clk),
    .rst   (rst),
    .din   (sync2[3:2]),
    .press (press)
  );

  // Free-running prescaler; never cleared so a rate change lands on the
  // next natural boundary of the new divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) presc <= '0;
    else     presc <= presc + 32'd1;
  end

  assign mask = slow_s ? MASK_S : MASK_F;
  assign tick = (presc & mask) == mask;

  // Next-state and grant decode; a breakpoint beats a same-cycle tick.
  always_comb begin
    state_n  = state;
    rem_n    = rem;
    grant    = 1'b0;
    hit_halt = 1'b0;
    case (state)
      S_HALT: begin
        if (run_s && !bkpt_halted) begin
          state_n = S_RUN;
        end else if (press[0]) begin
          state_n = S_STEP;
        end else if (press[1] && burst_len != 8'd0) begin
          state_n = S_BURST;
          rem_n   = burst_len;
        end
      end
      S_RUN: begin
        if (bkpt_hit) begin
          state_n  = S_HALT;
          hit_halt = 1'b1;
        end else if (!run_s) begin
          state_n = S_HALT;
        end else begin
          grant = tick;
        end
      end
      S_STEP: begin
        if (bkpt_hit) begin
          state_n  = S_HALT;
          hit_halt = 1'b1;
        end else if (tick) begin
          grant   = 1'b1;
          state_n = S_HALT;
        end
      end
      default: begin
        if (bkpt_hit) begin
          state_n  = S_HALT;
          hit_halt = 1'b1;
        end else if (tick) begin
          grant = 1'b1;
          rem_n = rem - 8'd1;
          if (rem == 8'd1) state_n = S_HALT;
        end
      end
    endcase
  end

  // State, burst remainder, registered enable and sticky breakpoint flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_HALT;
      rem         <= '0;
      cpu_ce      <= 1'b0;
      bkpt_halted <= 1'b0;
    end else begin
      state  <= state_n;
      rem    <= rem_n;
      cpu_ce <= grant;
      if (hit_halt)    bkpt_halted <= 1'b1;
      else if (!run_s) bkpt_halted <= 1'b0;
    end
  end

  // Pulse counter for the display; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ce_count <= '0;
    else if (cpu_ce) ce_count <= ce_count + 32'd1;
  end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed stimulus pushes the expected pulses
// (count seen during the pulse, spacing from the previous pulse) into a
// queue; a negedge monitor pops and checks each cpu_ce pulse.
module tb_cpu_run_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run_sw = 1'b0, slow_sw = 1'b0, step_btn = 1'b0, burst_btn = 1'b0;
  logic [7:0]  burst_len = 8'd0;
  logic        bkpt_hit = 1'b0;
  logic        cpu_ce;
  logic [1:0]  state;
  logic        bkpt_halted;
  logic [31:0] ce_count;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.DIV_FAST(2), .DIV_SLOW(4), .DB_BITS(3)) dut (
    .clk(clk), .rst(rst), .run_sw(run_sw), .slow_sw(slow_sw),
    .step_btn(step_btn), .burst_btn(burst_btn), .burst_len(burst_len),
    .bkpt_hit(bkpt_hit), .cpu_ce(cpu_ce), .state(state),
    .bkpt_halted(bkpt_halted), .ce_count(ce_count)
  );

  typedef struct {
    logic [31:0] cnt;
    int          gap;   // 0 = spacing not checked
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   since = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] cnt, input int gap);
    exp_t e;
    e.cnt = cnt;
    e.gap = gap;
    q.push_back(e);
  endtask

  // Monitor: every cpu_ce pulse must match the head of the queue.
  always @(negedge clk) begin
    if (rst) begin
      since = 0;
    end else begin
      since++;
      if (cpu_ce) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: cpu_ce=1 ce_count=%0h state=%0d, no pulse expected",
                   ce_count, state);
        end else begin
          mon_e = q.pop_front();
          chk("pulse_count", ce_count, mon_e.cnt);
          if (mon_e.gap != 0) chk("pulse_gap", 32'(since), 32'(mon_e.gap));
        end
        since = 0;
      end
    end
  end

  task automatic wait_ce(input string name, input int n, input int budget);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (cpu_ce) seen++;
    end
    chk(name, 32'(seen), 32'(n));
  endtask

  task automatic wait_state(input string name, input logic [1:0] s, input int budget);
    int cyc = 0;
    while (state != s && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk(name, 32'(state), 32'(s));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    // Reset values
    idle(3);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ce", 32'(cpu_ce), 32'd0);
    chk("rst_bkpt", 32'(bkpt_halted), 32'd0);
    chk("rst_count", ce_count, 32'd0);
    rst = 1'b0;

    // Free run fast: 4 clk spacing, then slow: 16 clk spacing
    for (int i = 0; i < 6; i++) push(32'(i), (i == 0) ? 0 : 4);
    run_sw = 1'b1;
    wait_state("enter_run", 2'b01, 20);
    wait_ce("fast_pulses", 6, 60);
    slow_sw = 1'b1;
    push(32'd6, 0);
    push(32'd7, 16);
    push(32'd8, 16);
    wait_ce("slow_pulses", 3, 80);
    run_sw = 1'b0;
    idle(10);
    chk("run_stop_state", 32'(state), 32'd0);
    chk("run_count", ce_count, 32'd9);
    slow_sw = 1'b0;
    idle(5);

    // Single step with glitches before a 12-clk hold
    push(32'd9, 0);
    for (int g = 0; g < 2; g++) begin
      step_btn = 1'b1; idle(2);
      step_btn = 1'b0; idle(2);
    end
    step_btn = 1'b1;
    wait_state("enter_step", 2'b10, 30);
    wait_ce("step_pulse", 1, 20);
    chk("step_to_halt", 32'(state), 32'd0);
    idle(4);
    step_btn = 1'b0;
    idle(20);
    chk("step_count", ce_count, 32'd10);
    step_btn = 1'b1; idle(5);
    step_btn = 1'b0; idle(20);
    chk("glitch_state", 32'(state), 32'd0);
    chk("glitch_count", ce_count, 32'd10);

    // Burst of 5, then a burst_len=0 press that must be ignored
    for (int i = 0; i < 5; i++) push(32'(10 + i), (i == 0) ? 0 : 4);
    burst_len = 8'd5;
    burst_btn = 1'b1;
    wait_ce("burst_pulses", 5, 100);
    chk("burst_end_state", 32'(state), 32'd0);
    burst_btn = 1'b0;
    idle(20);
    chk("burst_count", ce_count, 32'd15);
    burst_len = 8'd0;
    burst_btn = 1'b1; idle(12);
    burst_btn = 1'b0; idle(20);
    chk("burst0_state", 32'(state), 32'd0);
    chk("burst0_count", ce_count, 32'd15);

    // Breakpoint coincident with a tick
    push(32'd15, 0);
    push(32'd16, 4);
    run_sw = 1'b1;
    wait_ce("pre_bkpt_pulses", 2, 60);
    idle(3);
    bkpt_hit = 1'b1;
    idle(1);
    bkpt_hit = 1'b0;
    chk("bkpt_state", 32'(state), 32'd0);
    chk("bkpt_flag", 32'(bkpt_halted), 32'd1);
    idle(20);
    chk("bkpt_hold_state", 32'(state), 32'd0);
    chk("bkpt_hold_count", ce_count, 32'd17);
    run_sw = 1'b0;
    idle(6);
    chk("bkpt_clear", 32'(bkpt_halted), 32'd0);
    push(32'd17, 0);
    push(32'd18, 4);
    run_sw = 1'b1;
    wait_ce("resume_pulses", 2, 60);
    run_sw = 1'b0;
    idle(10);
    chk("resume_stop_state", 32'(state), 32'd0);
    chk("resume_count", ce_count, 32'd19);

    // Reset in the middle of a long burst
    push(32'd19, 0);
    push(32'd20, 4);
    push(32'd21, 4);
    burst_len = 8'd200;
    burst_btn = 1'b1;
    wait_ce("long_burst_pulses", 3, 100);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ce", 32'(cpu_ce), 32'd0);
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_count", ce_count, 32'd0);
    burst_btn = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(30);
    chk("postrst_state", 32'(state), 32'd0);
    chk("postrst_count", ce_count, 32'd0);

    // Counter wrap
    force dut.ce_count = 32'hFFFF_FFFF;
    idle(1);
    release dut.ce_count;
    push(32'hFFFF_FFFF, 0);
    step_btn = 1'b1;
    wait_ce("wrap_pulse", 1, 40);
    step_btn = 1'b0;
    idle(10);
    chk("wrap_count", ce_count, 32'd0);

    idle(5);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
